sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_out_reg.sv | 75 +++++++
 rtl/sipo_deser.sv | 125 ++++++++++++
 tb/tb_sipo_deser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types for the SIPO deserialiser: FSM state encoding and default word width.
// Build option SIPO_PARITY_EN adds the PAR state for a trailing even-parity bit.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
`endif

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register for the SIPO deserialiser: valid/ready handshake and overflow flag.
// With SIPO_PARITY_EN it also carries the parity-error pulse alongside each completed word.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
`ifdef SIPO_PARITY_EN
  input  logic             perr_i,
  output logic             par_err_o,
`endif
  input  logic             rdy_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  // A new word may replace the held one only when the slot is empty or being drained this edge.
  assign accept = !vld_q || rdy_i;

  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    ovf_d  = 1'b0;
    if (load_i && accept) begin
      dout_d = word_i;
      vld_d  = 1'b1;
    end else if (load_i) begin
      ovf_d = 1'b1;
    end else if (vld_q && rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q;

  // Parity errors are reported for dropped words as well as delivered ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= load_i && perr_i;
    end
  end

  assign par_err_o = perr_q;
`endif

  assign dout_o = dout_q;
  assign vld_o  = vld_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser: assembles WIDTH bits LSB first into a word.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame and expose par_err.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf
`ifdef SIPO_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word;
  logic             word_done;
`ifdef SIPO_PARITY_EN
  logic             par_bad;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (din_vld) begin
      case (state_q)
        IDLE:    state_d = SHIFT;
`ifdef SIPO_PARITY_EN
        SHIFT:   if (cnt_q == LAST) state_d = PAR;
        PAR:     state_d = IDLE;
`else
        SHIFT:   if (cnt_q == LAST) state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    word_done = 1'b0;
`ifdef SIPO_PARITY_EN
    par_bad   = 1'b0;
    if (din_vld && state_q == PAR) begin
      word_done = 1'b1;
      par_bad   = ^{shreg_q, din};
    end
`else
    if (din_vld && state_q == SHIFT && cnt_q == LAST) begin
      word_done = 1'b1;
    end
`endif
  end

  // Each bit is written at the counter position so the first bit lands in bit 0.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (din_vld) begin
`ifdef SIPO_PARITY_EN
      if (state_q == PAR) begin
        cnt_d = '0;
      end else begin
        shreg_d[cnt_q] = din;
        cnt_d = (cnt_q == LAST) ? LAST : cnt_q + CW'(1);
      end
`else
      shreg_d[cnt_q] = din;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef SIPO_PARITY_EN
  assign word = shreg_q;
`else
  assign word = shreg_d;
`endif

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (word_done),
    .word_i   (word),
`ifdef SIPO_PARITY_EN
    .perr_i   (par_bad),
    .par_err_o(par_err),
`endif
    .rdy_i    (dout_rdy),
    .dout_o   (dout),
    .vld_o    (dout_vld),
    .ovf_o    (ovf)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser at WIDTH=8 with hand-computed expected words.
// With SIPO_PARITY_EN defined each frame gets its even-parity bit and parity checks run.
module tb_sipo_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din = 1'b0;
  logic         din_vld = 1'b0;
  logic         dout_rdy = 1'b0;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         ovf;
`ifdef SIPO_PARITY_EN
  logic         par_err;
`endif

  int vecCount = 0;
  int missCount = 0;

  sipo_deser #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .ovf     (ovf)
`ifdef SIPO_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  // One clock: drive at the falling edge, return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic b, input logic v, input logic r);
    @(negedge clk);
    din      = b;
    din_vld  = v;
    dout_rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [W-1:0] w, input logic rBody, input logic rLast);
    logic [W-1:0] wv;
    wv = w;
`ifdef SIPO_PARITY_EN
    for (int i = 0; i < W; i++) applyStimulus(wv[i], 1'b1, rBody);
    applyStimulus(^wv, 1'b1, rLast);
`else
    for (int i = 0; i < W - 1; i++) applyStimulus(wv[i], 1'b1, rBody);
    applyStimulus(wv[W-1], 1'b1, rLast);
`endif
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    vecCount++;
    if (dout !== 8'h00 || dout_vld !== 1'b0 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_state: dout=%h vld=%b ovf=%b, want 00/0/0", dout, dout_vld, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 8'h4D;
    for (int i = 0; i < W; i++) begin
      applyStimulus(w[i], 1'b1, 1'b1);
      if (i == 6) begin
        vecCount++;
        if (dout_vld !== 1'b0) begin
          missCount++;
          $display("[TB] FAIL basic_early_vld: vld=%b, want 0", dout_vld);
        end
      end
    end
`ifdef SIPO_PARITY_EN
    applyStimulus(1'b0, 1'b1, 1'b1);
`endif
    vecCount++;
    if (dout !== 8'h4D || dout_vld !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL basic_word: dout=%h vld=%b, want 4d/1", dout, dout_vld);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    vecCount++;
    if (dout_vld !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL basic_clear: vld=%b, want 0", dout_vld);
    end
  endtask

  task automatic test_gap();
    logic [W-1:0] w;
    w = 8'h4D;
    for (int i = 0; i < 4; i++) applyStimulus(w[i], 1'b1, 1'b1);
    for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, 1'b1);
    vecCount++;
    if (dout_vld !== 1'b0 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL gap_hold: vld=%b ovf=%b, want 0/0", dout_vld, ovf);
    end
    for (int i = 4; i < W; i++) applyStimulus(w[i], 1'b1, 1'b1);
`ifdef SIPO_PARITY_EN
    applyStimulus(1'b0, 1'b1, 1'b1);
`endif
    vecCount++;
    if (dout !== 8'h4D || dout_vld !== 1'b1 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL gap_word: dout=%h vld=%b ovf=%b, want 4d/1/0", dout, dout_vld, ovf);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    vecCount++;
    if (dout_vld !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL gap_clear: vld=%b, want 0", dout_vld);
    end
  endtask

  task automatic test_overflow();
    sendWord(8'hA5, 1'b0, 1'b0);
    vecCount++;
    if (dout !== 8'hA5 || dout_vld !== 1'b1 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL ovf_first: dout=%h vld=%b ovf=%b, want a5/1/0", dout, dout_vld, ovf);
    end
    sendWord(8'h3C, 1'b0, 1'b0);
    vecCount++;
    if (dout !== 8'hA5 || dout_vld !== 1'b1 || ovf !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL ovf_drop: dout=%h vld=%b ovf=%b, want a5/1/1", dout, dout_vld, ovf);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    vecCount++;
    if (dout !== 8'hA5 || dout_vld !== 1'b1 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL ovf_pulse_end: dout=%h vld=%b ovf=%b, want a5/1/0", dout, dout_vld, ovf);
    end
  endtask

  task automatic test_back_to_back();
    sendWord(8'hFF, 1'b0, 1'b1);
    vecCount++;
    if (dout !== 8'hFF || dout_vld !== 1'b1 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL b2b_replace: dout=%h vld=%b ovf=%b, want ff/1/0", dout, dout_vld, ovf);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    vecCount++;
    if (dout_vld !== 1'b0 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL b2b_clear: vld=%b ovf=%b, want 0/0", dout_vld, ovf);
    end
  endtask

  task automatic test_reset_midword();
    sendWord(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    vecCount++;
    if (dout !== 8'h00 || dout_vld !== 1'b0 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL async_reset: dout=%h vld=%b ovf=%b, want 00/0/0", dout, dout_vld, ovf);
    end
    @(negedge clk);
    din_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sendWord(8'h81, 1'b1, 1'b1);
    vecCount++;
    if (dout !== 8'h81 || dout_vld !== 1'b1 || ovf !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_residue: dout=%h vld=%b ovf=%b, want 81/1/0", dout, dout_vld, ovf);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    vecCount++;
    if (dout_vld !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_clear: vld=%b, want 0", dout_vld);
    end
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w;
    w = 8'h07;
    for (int i = 0; i < W; i++) applyStimulus(w[i], 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    vecCount++;
    if (dout !== 8'h07 || dout_vld !== 1'b1 || par_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL parity_good: dout=%h vld=%b perr=%b, want 07/1/0", dout, dout_vld, par_err);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) applyStimulus(w[i], 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    vecCount++;
    if (dout !== 8'h07 || dout_vld !== 1'b1 || par_err !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL parity_bad: dout=%h vld=%b perr=%b, want 07/1/1", dout, dout_vld, par_err);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    vecCount++;
    if (par_err !== 1'b0 || dout_vld !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL parity_pulse_end: perr=%b vld=%b, want 0/0", par_err, dout_vld);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_back_to_back();
    test_reset_midword();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
